// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: datapath widths, ALU control codes,
// forwarding selects and branch funct3 encodings.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // ALU control codes produced by the ALU decoder
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Operand forwarding selects (2'b11 falls back to the register file)
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Branch conditions (funct3); 010 and 011 are never taken
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// master: the pipeline side driving ID/EX fields and hazard controls.
// slave : the execute stage itself.
// Optional perf counters appear when EX_PERF_CNT_EN is defined.
// Handshake: there is no backpressure handshake; valid_i marks a real
// instruction (0 = bubble), stall_i holds and flush_i clears the EX/MEM
// register, and valid_o qualifies the registered EX/MEM outputs.
interface ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              valid_i;
  logic [3:0]        alu_ctrl_i;
  logic [XLEN-1:0]   rs1_data_i;
  logic [XLEN-1:0]   rs2_data_i;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   pc_i;
  logic              alusrc_i;
  logic [1:0]        fwd_a_i;
  logic [1:0]        fwd_b_i;
  logic [XLEN-1:0]   wb_result_i;
  logic [2:0]        funct3_i;
  logic              branch_i;
  logic              jump_i;
  logic              jalr_i;
  logic [REG_AW-1:0] rd_i;
  logic              regwrite_i;
  logic              memwrite_i;
  logic [1:0]        resultsrc_i;
  logic              stall_i;
  logic              flush_i;

  logic              pc_src_o;
  logic [XLEN-1:0]   pc_target_o;
  logic [XLEN-1:0]   alu_result_o;
  logic [XLEN-1:0]   write_data_o;
  logic [XLEN-1:0]   pc_plus4_o;
  logic [REG_AW-1:0] rd_o;
  logic              regwrite_o;
  logic              memwrite_o;
  logic              valid_o;
  logic [1:0]        resultsrc_o;
`ifdef EX_PERF_CNT_EN
  logic [31:0]       perf_exec_o;
  logic [31:0]       perf_taken_o;
`endif

`ifdef EX_PERF_CNT_EN
  modport master (
    output valid_i, alu_ctrl_i, rs1_data_i, rs2_data_i, imm_i, pc_i, alusrc_i,
           fwd_a_i, fwd_b_i, wb_result_i, funct3_i, branch_i, jump_i, jalr_i,
           rd_i, regwrite_i, memwrite_i, resultsrc_i, stall_i, flush_i,
    input  pc_src_o, pc_target_o, alu_result_o, write_data_o, pc_plus4_o,
           rd_o, regwrite_o, memwrite_o, valid_o, resultsrc_o,
           perf_exec_o, perf_taken_o
  );
  modport slave (
    input  valid_i, alu_ctrl_i, rs1_data_i, rs2_data_i, imm_i, pc_i, alusrc_i,
           fwd_a_i, fwd_b_i, wb_result_i, funct3_i, branch_i, jump_i, jalr_i,
           rd_i, regwrite_i, memwrite_i, resultsrc_i, stall_i, flush_i,
    output pc_src_o, pc_target_o, alu_result_o, write_data_o, pc_plus4_o,
           rd_o, regwrite_o, memwrite_o, valid_o, resultsrc_o,
           perf_exec_o, perf_taken_o
  );
`else
  modport master (
    output valid_i, alu_ctrl_i, rs1_data_i, rs2_data_i, imm_i, pc_i, alusrc_i,
           fwd_a_i, fwd_b_i, wb_result_i, funct3_i, branch_i, jump_i, jalr_i,
           rd_i, regwrite_i, memwrite_i, resultsrc_i, stall_i, flush_i,
    input  pc_src_o, pc_target_o, alu_result_o, write_data_o, pc_plus4_o,
           rd_o, regwrite_o, memwrite_o, valid_o, resultsrc_o
  );
  modport slave (
    input  valid_i, alu_ctrl_i, rs1_data_i, rs2_data_i, imm_i, pc_i, alusrc_i,
           fwd_a_i, fwd_b_i, wb_result_i, funct3_i, branch_i, jump_i, jalr_i,
           rd_i, regwrite_i, memwrite_i, resultsrc_i, stall_i, flush_i,
    output pc_src_o, pc_target_o, alu_result_o, write_data_o, pc_plus4_o,
           rd_o, regwrite_o, memwrite_o, valid_o, resultsrc_o
  );
`endif

endinterface

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU. Shifts use b_i[4:0]; unused codes yield 0.
module alu #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      alu_ctrl_i,
  output logic [XLEN-1:0] result_o
);
  import rv32_pkg::*;

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b_i[4:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  // Select the operation result for the current control code
  always_comb begin
    result_o = '0;
    case (alu_ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution,
// combinational PC redirect and the EX/MEM pipeline register
// (priority: async reset > flush > stall > load).
// Optional macro EX_PERF_CNT_EN adds executed/taken perf counters.
module ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave bus
);
  import rv32_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   pc_plus4;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memwrite;
    logic [1:0]        resultsrc;
  } exmem_t;

  exmem_t          exmem_q, exmem_d;
  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res;
  logic            taken;
  logic            pc_src;
  logic            load;

  // Forwarding muxes for rs1 and rs2
  always_comb begin
    fwd_a = bus.rs1_data_i;
    fwd_b = bus.rs2_data_i;
    case (bus.fwd_a_i)
      FWD_WB:  fwd_a = bus.wb_result_i;
      FWD_MEM: fwd_a = exmem_q.alu_result;
      default: fwd_a = bus.rs1_data_i;
    endcase
    case (bus.fwd_b_i)
      FWD_WB:  fwd_b = bus.wb_result_i;
      FWD_MEM: fwd_b = exmem_q.alu_result;
      default: fwd_b = bus.rs2_data_i;
    endcase
  end

  assign op_b = bus.alusrc_i ? bus.imm_i : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .a_i        (fwd_a),
    .b_i        (op_b),
    .alu_ctrl_i (bus.alu_ctrl_i),
    .result_o   (alu_res)
  );

  // Branch condition on forwarded rs1 vs rs2, independent of the ALU code
  always_comb begin
    taken = 1'b0;
    case (bus.funct3_i)
      F3_BEQ:  taken = (fwd_a == fwd_b);
      F3_BNE:  taken = (fwd_a != fwd_b);
      F3_BLT:  taken = ($signed(fwd_a) <  $signed(fwd_b));
      F3_BGE:  taken = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: taken = (fwd_a <  fwd_b);
      F3_BGEU: taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  // A stalled instruction will be replayed, so it must not redirect yet
  assign pc_src          = bus.valid_i & ~bus.stall_i &
                           (bus.jump_i | (bus.branch_i & taken));
  assign bus.pc_src_o    = pc_src;
  assign bus.pc_target_o = bus.jalr_i
                         ? ((fwd_a + bus.imm_i) & ~{{(XLEN-1){1'b0}}, 1'b1})
                         : (bus.pc_i + bus.imm_i);

  assign load = ~bus.flush_i & ~bus.stall_i;

  // EX/MEM next state: flush clears to a bubble, stall holds, else load
  always_comb begin
    exmem_d = exmem_q;
    if (bus.flush_i) begin
      exmem_d = '0;
    end else if (!bus.stall_i) begin
      exmem_d.valid      = bus.valid_i;
      exmem_d.alu_result = alu_res;
      exmem_d.write_data = fwd_b;
      exmem_d.pc_plus4   = bus.pc_i + XLEN'(4);
      exmem_d.rd         = bus.rd_i;
      exmem_d.regwrite   = bus.regwrite_i & bus.valid_i;
      exmem_d.memwrite   = bus.memwrite_i & bus.valid_i;
      exmem_d.resultsrc  = bus.resultsrc_i;
    end
  end

  // EX/MEM register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) exmem_q <= '0;
    else       exmem_q <= exmem_d;
  end

  assign bus.valid_o      = exmem_q.valid;
  assign bus.alu_result_o = exmem_q.alu_result;
  assign bus.write_data_o = exmem_q.write_data;
  assign bus.pc_plus4_o   = exmem_q.pc_plus4;
  assign bus.rd_o         = exmem_q.rd;
  assign bus.regwrite_o   = exmem_q.regwrite;
  assign bus.memwrite_o   = exmem_q.memwrite;
  assign bus.resultsrc_o  = exmem_q.resultsrc;

`ifdef EX_PERF_CNT_EN
  logic [31:0] perf_exec_q, perf_exec_d;
  logic [31:0] perf_taken_q, perf_taken_d;

  // Counter next state; a flush cycle changes neither counter
  always_comb begin
    perf_exec_d  = perf_exec_q;
    perf_taken_d = perf_taken_q;
    if (load && bus.valid_i) perf_exec_d  = perf_exec_q + 32'd1;
    if (pc_src && !bus.flush_i) perf_taken_d = perf_taken_q + 32'd1;
  end

  // Perf counter registers, wrapping naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_exec_q  <= '0;
      perf_taken_q <= '0;
    end else begin
      perf_exec_q  <= perf_exec_d;
      perf_taken_q <= perf_taken_d;
    end
  end

  assign bus.perf_exec_o  = perf_exec_q;
  assign bus.perf_taken_o = perf_taken_q;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized
// traffic against a behavioural model; EX/MEM results go through an
// expected queue checked by a monitor one clock after issue.
module tb_ex_stage;

  logic clk;
  logic reset;

  ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- expected state ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
`ifdef EX_PERF_CNT_EN
    logic [31:0] pexec;
    logic [31:0] ptaken;
`endif
  } exm_t;

  localparam int W = $bits(exm_t);

  logic [W-1:0] exp_q[$];
  exm_t         m;          // model of the EX/MEM register contents
  logic [31:0]  m_exec;
  logic [31:0]  m_taken;
  int           n_checks;
  int           n_err;

  // ---------------- reference model ----------------
  function automatic logic lt_signed(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    return a < b;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] ones;
    sh   = b % 32;
    ones = 32'hFFFF_FFFF;
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return {31'd0, lt_signed(a, b)};
      4'd6: return a >> sh;
      4'd7: return a << sh;
      4'd8: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
      4'd9: return {31'd0, (a < b)};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return lt_signed(a, b);
      3'b101: return !lt_signed(a, b);
      3'b110: return a < b;
      3'b111: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick_fwd(input logic [1:0] s,
                                           input logic [31:0] rf,
                                           input logic [31:0] wb,
                                           input logic [31:0] mem);
    if (s == 2'b01) return wb;
    if (s == 2'b10) return mem;
    return rf;
  endfunction

  function automatic exm_t dut_state();
    exm_t g;
    g.valid = bus.valid_o;
    g.alu   = bus.alu_result_o;
    g.wd    = bus.write_data_o;
    g.pc4   = bus.pc_plus4_o;
    g.rd    = bus.rd_o;
    g.rw    = bus.regwrite_o;
    g.mw    = bus.memwrite_o;
    g.rs    = bus.resultsrc_o;
`ifdef EX_PERF_CNT_EN
    g.pexec  = bus.perf_exec_o;
    g.ptaken = bus.perf_taken_o;
`endif
    return g;
  endfunction

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.valid_i     = 1'b0;
    bus.alu_ctrl_i  = 4'd0;
    bus.rs1_data_i  = 32'd0;
    bus.rs2_data_i  = 32'd0;
    bus.imm_i       = 32'd0;
    bus.pc_i        = 32'd0;
    bus.alusrc_i    = 1'b0;
    bus.fwd_a_i     = 2'b00;
    bus.fwd_b_i     = 2'b00;
    bus.wb_result_i = 32'd0;
    bus.funct3_i    = 3'b010;
    bus.branch_i    = 1'b0;
    bus.jump_i      = 1'b0;
    bus.jalr_i      = 1'b0;
    bus.rd_i        = 5'd0;
    bus.regwrite_i  = 1'b0;
    bus.memwrite_i  = 1'b0;
    bus.resultsrc_i = 2'b00;
    bus.stall_i     = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_inputs();
    bus.valid_i     = ($urandom_range(0, 4) != 0);
    bus.alu_ctrl_i  = 4'($urandom_range(0, 15));
    bus.rs1_data_i  = rand_word();
    bus.rs2_data_i  = rand_word();
    bus.imm_i       = rand_word();
    bus.pc_i        = $urandom & 32'hFFFF_FFFC;
    bus.alusrc_i    = 1'($urandom_range(0, 1));
    bus.fwd_a_i     = 2'($urandom_range(0, 3));
    bus.fwd_b_i     = 2'($urandom_range(0, 3));
    bus.wb_result_i = rand_word();
    bus.funct3_i    = 3'($urandom_range(0, 7));
    bus.branch_i    = 1'($urandom_range(0, 1));
    bus.jump_i      = ($urandom_range(0, 5) == 0);
    bus.jalr_i      = 1'($urandom_range(0, 1));
    bus.rd_i        = 5'($urandom_range(0, 31));
    bus.regwrite_i  = 1'($urandom_range(0, 1));
    bus.memwrite_i  = 1'($urandom_range(0, 1));
    bus.resultsrc_i = 2'($urandom_range(0, 3));
    bus.stall_i     = ($urandom_range(0, 7) == 0);
    bus.flush_i     = ($urandom_range(0, 7) == 0);
  endtask

  // Called at a falling edge with inputs applied: checks the redirect,
  // queues the expected EX/MEM contents, and returns at the next falling edge.
  task automatic cycle();
    logic [31:0] fa, fb, ob, tgt;
    logic        src;
    exm_t        n;
    #1;
    fa  = pick_fwd(bus.fwd_a_i, bus.rs1_data_i, bus.wb_result_i, m.alu);
    fb  = pick_fwd(bus.fwd_b_i, bus.rs2_data_i, bus.wb_result_i, m.alu);
    ob  = bus.alusrc_i ? bus.imm_i : fb;
    src = bus.valid_i && !bus.stall_i &&
          (bus.jump_i || (bus.branch_i && ref_taken(bus.funct3_i, fa, fb)));
    tgt = bus.jalr_i ? ((fa + bus.imm_i) & 32'hFFFF_FFFE) : (bus.pc_i + bus.imm_i);
    chk("pc_src", {31'd0, bus.pc_src_o}, {31'd0, src});
    chk("pc_target", bus.pc_target_o, tgt);

    n = m;
    if (bus.flush_i) begin
      n = '0;
    end else if (!bus.stall_i) begin
      n.valid = bus.valid_i;
      n.alu   = ref_alu(bus.alu_ctrl_i, fa, ob);
      n.wd    = fb;
      n.pc4   = bus.pc_i + 32'd4;
      n.rd    = bus.rd_i;
      n.rw    = bus.regwrite_i && bus.valid_i;
      n.mw    = bus.memwrite_i && bus.valid_i;
      n.rs    = bus.resultsrc_i;
      if (bus.valid_i) m_exec = m_exec + 32'd1;
    end
    if (src && !bus.flush_i) m_taken = m_taken + 32'd1;
`ifdef EX_PERF_CNT_EN
    n.pexec  = m_exec;
    n.ptaken = m_taken;
`endif
    exp_q.push_back(W'(n));
    m = n;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  exm_t mon_got;
  exm_t mon_exp;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exm_t'(exp_q.pop_front());
      mon_got = dut_state();
      n_checks++;
      if (mon_got !== mon_exp) begin
        n_err++;
        $display("FAIL exmem: got v=%0d alu=%h wd=%h pc4=%h rd=%0d rw=%0d mw=%0d rs=%0d expected v=%0d alu=%h wd=%h pc4=%h rd=%0d rw=%0d mw=%0d rs=%0d",
                 mon_got.valid, mon_got.alu, mon_got.wd, mon_got.pc4, mon_got.rd,
                 mon_got.rw, mon_got.mw, mon_got.rs,
                 mon_exp.valid, mon_exp.alu, mon_exp.wd, mon_exp.pc4, mon_exp.rd,
                 mon_exp.rw, mon_exp.mw, mon_exp.rs);
`ifdef EX_PERF_CNT_EN
        $display("FAIL perf: got exec=%0d taken=%0d expected exec=%0d taken=%0d",
                 mon_got.pexec, mon_got.ptaken, mon_exp.pexec, mon_exp.ptaken);
`endif
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_err    = 0;
    m        = '0;
    m_exec   = 32'd0;
    m_taken  = 32'd0;
    reset    = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("rst_alu", bus.alu_result_o, 32'd0);
    chk("rst_regwrite", {31'd0, bus.regwrite_o}, 32'd0);
    chk("rst_pc4", bus.pc_plus4_o, 32'd0);
    reset = 1'b0;

    // 1: ADD rs1 + imm with signed overflow
    bus.valid_i = 1'b1; bus.alu_ctrl_i = 4'b0000; bus.rs1_data_i = 32'h7FFF_FFFF;
    bus.imm_i = 32'd1; bus.alusrc_i = 1'b1; bus.regwrite_i = 1'b1; bus.rd_i = 5'd5;
    cycle();
    chk("t1_alu", bus.alu_result_o, 32'h8000_0000);
    chk("t1_valid", {31'd0, bus.valid_o}, 32'd1);

    // 2: SRA with operand A forwarded from EX/MEM, then from writeback
    bus.fwd_a_i = 2'b10; bus.imm_i = 32'd4; bus.alu_ctrl_i = 4'b1000;
    bus.rs1_data_i = 32'd0;
    cycle();
    chk("t2_sra_mem", bus.alu_result_o, 32'hF800_0000);
    bus.fwd_a_i = 2'b01; bus.wb_result_i = 32'h8000_0000;
    cycle();
    chk("t2_sra_wb", bus.alu_result_o, 32'hF800_0000);

    // 3: BLT taken, BLTU not taken
    set_idle();
    bus.valid_i = 1'b1; bus.rs1_data_i = 32'hFFFF_FFFF; bus.rs2_data_i = 32'd1;
    bus.branch_i = 1'b1; bus.funct3_i = 3'b100; bus.pc_i = 32'h100; bus.imm_i = 32'h20;
    #1;
    chk("t3_blt_src", {31'd0, bus.pc_src_o}, 32'd1);
    chk("t3_blt_tgt", bus.pc_target_o, 32'h120);
    cycle();
    bus.funct3_i = 3'b110;
    #1;
    chk("t3_bltu_src", {31'd0, bus.pc_src_o}, 32'd0);
    cycle();

    // 4: JALR clears bit 0 of the target
    set_idle();
    bus.valid_i = 1'b1; bus.jump_i = 1'b1; bus.jalr_i = 1'b1; bus.rs1_data_i = 32'h1003;
    bus.imm_i = 32'd0; bus.pc_i = 32'h200; bus.regwrite_i = 1'b1; bus.rd_i = 5'd1;
    #1;
    chk("t4_tgt", bus.pc_target_o, 32'h1002);
    chk("t4_src", {31'd0, bus.pc_src_o}, 32'd1);
    cycle();
    chk("t4_pc4", bus.pc_plus4_o, 32'h204);

    // 5: stall holds and suppresses redirect; flush beats stall
    bus.pc_i = 32'h300; bus.rs1_data_i = 32'h55; bus.stall_i = 1'b1;
    #1;
    chk("t5_stall_src", {31'd0, bus.pc_src_o}, 32'd0);
    cycle();
    chk("t5_stall_pc4", bus.pc_plus4_o, 32'h204);
    chk("t5_stall_rw", {31'd0, bus.regwrite_o}, 32'd1);
    bus.flush_i = 1'b1;
    cycle();
    chk("t5_flush_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("t5_flush_rw", {31'd0, bus.regwrite_o}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    // asynchronous reset between clock edges
    set_idle();
    bus.valid_i = 1'b1; bus.regwrite_i = 1'b1; bus.memwrite_i = 1'b1; bus.pc_i = 32'h40;
    bus.rs1_data_i = 32'h1234; bus.alusrc_i = 1'b1; bus.imm_i = 32'h1; bus.jump_i = 1'b1;
    cycle();
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("arst_alu", bus.alu_result_o, 32'd0);
    chk("arst_pc4", bus.pc_plus4_o, 32'd0);
    chk("arst_rw", {31'd0, bus.regwrite_o}, 32'd0);
    chk("arst_mw", {31'd0, bus.memwrite_o}, 32'd0);
`ifdef EX_PERF_CNT_EN
    chk("arst_pexec", bus.perf_exec_o, 32'd0);
    chk("arst_ptaken", bus.perf_taken_o, 32'd0);
`endif
    #1 reset = 1'b0;
    m = '0; m_exec = 32'd0; m_taken = 32'd0;
    @(negedge clk);

    // 6: three valid ops (one a taken BEQ) and one bubble
    set_idle();
    bus.valid_i = 1'b1; bus.alu_ctrl_i = 4'b0010; bus.rs1_data_i = 32'hF0F0; bus.rs2_data_i = 32'hFF00;
    cycle();
    bus.alu_ctrl_i = 4'b1001; bus.branch_i = 1'b1; bus.funct3_i = 3'b000;
    bus.rs2_data_i = 32'hF0F0; bus.pc_i = 32'h80; bus.imm_i = 32'h10;
    cycle();
    bus.branch_i = 1'b0; bus.alu_ctrl_i = 4'b0111; bus.rs2_data_i = 32'd3;
    cycle();
    bus.valid_i = 1'b0;
    cycle();
`ifdef EX_PERF_CNT_EN
    chk("t6_pexec", bus.perf_exec_o, 32'd3);
    chk("t6_ptaken", bus.perf_taken_o, 32'd1);
`endif

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipelined RV32I core. Sits directly downstream of the ALU decoder and consumes its 4-bit ALU control code together with the ID/EX operands.
- Performs operand forwarding, the ALU operation, branch/jump resolution and PC-redirect generation.
- Holds the result in the EX/MEM pipeline register. That register supports stall and flush and feeds the memory stage.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_i  in  1  ID/EX holds a real instruction (0 = bubble).
- alu_ctrl_i  in  4  ALU control code from the ALU decoder.
- rs1_data_i, rs2_data_i  in  XLEN  register-file read data.
- imm_i, pc_i  in  XLEN  extended immediate; instruction PC.
- alusrc_i  in  1  operand B select: 0 = forwarded rs2, 1 = imm.
- fwd_a_i, fwd_b_i  in  2  forward select: 00 = regfile, 01 = wb_result_i, 10 = exmem alu_result_o, 11 = regfile.
- wb_result_i  in  XLEN  writeback-stage result.
- funct3_i  in  3  branch condition.
- branch_i, jump_i, jalr_i  in  1  control-flow flags.
- rd_i  in  REG_AW; regwrite_i  in  1; memwrite_i  in  1; resultsrc_i  in  2  control fields passed down the pipe.
- stall_i, flush_i  in  1  hazard-unit controls for the EX/MEM register.
- pc_src_o  out  1  combinational redirect request.
- pc_target_o  out  XLEN  combinational redirect address.
- alu_result_o, write_data_o, pc_plus4_o  out  XLEN  registered EX/MEM data.
- rd_o  out  REG_AW; regwrite_o, memwrite_o, valid_o  out  1; resultsrc_o  out  2  registered EX/MEM control.

Behaviour:
- Operand A is the forwarded rs1. Operand B is imm when alusrc_i=1, else the forwarded rs2. write_data comes from the forwarded rs2 regardless of alusrc_i.
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed): result 0 or 1.
  - 0110 SRL, 0111 SLL, 1000 SRA: shift amount is B[4:0].
  - 1001 SLTU: result 0 or 1.
  - 1010–1111: result 0.
- All arithmetic is modulo 2^XLEN.
- Branch condition is evaluated on the forwarded rs1 vs forwarded rs2, independent of alu_ctrl_i:
  - funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010 and 011 are never taken.
- Redirect:
  - pc_src_o = valid_i & ~stall_i & (jump_i | (branch_i & taken)).
  - pc_target_o = jalr_i ? ((fwdA + imm) & ~1) : (pc_i + imm). Always driven.
- EX/MEM register update, priority reset > flush > stall > load:
  - reset (async) or flush_i: all registered outputs go to 0, including valid_o (bubble). A bubble forces regwrite_o = memwrite_o = 0.
  - stall_i (no flush): all registered outputs hold.
  - Otherwise: load. valid_o = valid_i. regwrite_o = regwrite_i & valid_i. memwrite_o = memwrite_i & valid_i. pc_plus4_o = pc_i + 4. Remaining fields are captured directly.
- Latency is one cycle from ID/EX inputs to EX/MEM outputs. Redirect is the same cycle (combinational).
- Reset asserted mid-operation clears the register immediately, without waiting for a clock edge. The first load happens on the first rising clk edge after reset deasserts.
- When flush_i and stall_i are high in the same cycle, flush wins.

Optional Feature:
- Macro: EX_PERF_CNT_EN.
- With the macro defined:
  - Two 32-bit counters, perf_exec_o and perf_taken_o, are added as outputs; both reset to 0.
  - perf_exec_o increments on each load with valid_i=1.
  - perf_taken_o increments on each cycle with pc_src_o=1.
  - Both wrap at 2^32 to 0. Neither changes during stall, flush or reset.
- Without the macro: the ports and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package rv32_pkg holds:
  - ALU control constants ALU_ADD … ALU_SLTU (4-bit values as listed above).
  - Forward-select constants FWD_RF / FWD_WB / FWD_MEM.
  - Branch funct3 constants.
  - XLEN.
- One sub-module, alu (combinational: a, b, alu_ctrl → result), instantiated once.
- Forwarding muxes, branch compare and the EX/MEM register stay in ex_stage.

Test Plan:
1. ADD via rs1 plus imm: alu_ctrl=0000, rs1=0x7FFF_FFFF, imm=1, alusrc=1 → next cycle alu_result_o=0x8000_0000, valid_o=1.
2. Forwarding plus SRA: fwd_a=10 with exmem result 0x8000_0000, B=4, alu_ctrl=1000 → 0xF800_0000. The same with fwd_a=01 uses wb_result_i.
3. BLT: rs1=0xFFFF_FFFF, rs2=1, branch=1, funct3=100, pc=0x100, imm=0x20 → pc_src_o=1, pc_target_o=0x120 in the same cycle. With funct3=110 (BLTU) → pc_src_o=0.
4. JALR: rs1=0x1003, imm=0 → pc_target_o=0x1002, pc_src_o=1, pc_plus4_o=pc+4.
5. Stall then flush:
   - stall_i=1 with new inputs → outputs hold the prior values and pc_src_o=0.
   - stall_i=1 and flush_i=1 together → valid_o=0 and regwrite_o=0 next cycle.
   - reset pulse between clock edges → all outputs 0 immediately.
6. With EX_PERF_CNT_EN defined: 3 valid ops, 1 bubble and 1 taken branch → perf_exec_o=3, perf_taken_o=1.
